i2c_write_scheduler: RTL

//  Arbitrates NREQ requesters (VCM focus, sensor register writer, ...) onto one shared
//  I2C 3-byte write engine (slave addr, pointer, data). Sequences the engine's GO/END_OK

---
 rtl/i2c_write_scheduler_pkg.sv | 31 +++
 rtl/i2c_write_scheduler_if.sv | 31 +++
 rtl/i2c_write_scheduler_rr_arbiter.sv | 38 +++
 rtl/i2c_write_scheduler.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/i2c_write_scheduler_pkg.sv
// Shared types and constants for the I2C write scheduler: FSM encodings,
// the 3-byte write command and the saturating error-counter helper.
package i2c_sched_pkg;

  localparam int I2C_BYTE_W = 8;

  typedef logic [I2C_BYTE_W-1:0] byte_t;

  // Plain encodings keep the state register readable in legacy netlists and waveforms.
  typedef logic [2:0] state_t;
  localparam state_t S_BOOT     = 3'd0;
  localparam state_t S_IDLE     = 3'd1;
  localparam state_t S_LAUNCH   = 3'd2;
  localparam state_t S_WAIT_END = 3'd3;
  localparam state_t S_RETRY    = 3'd4;
  localparam state_t S_DONE     = 3'd5;
  localparam state_t S_FAIL     = 3'd6;

  localparam byte_t ERR_CNT_MAX = 8'hFF;

  typedef struct packed {
    byte_t slave;
    byte_t ptr;
    byte_t data;
  } wr_cmd_t;

  function automatic byte_t sat_inc(input byte_t v);
    return (v == ERR_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_write_scheduler_if.sv
// Handshake and data bus between the scheduler (master) and the shared
// 3-byte I2C write engine (slave).
interface i2c_eng_if;
  import i2c_sched_pkg::*;

  logic  I2C_GO;
  byte_t I2C_SLAVE_ADDRESS;
  byte_t I2C_POINTER;
  byte_t I2C_WDATA8;
  logic  I2C_END_OK;
  logic  I2C_ACK_OK;

  modport master (
    output I2C_GO,
    output I2C_SLAVE_ADDRESS,
    output I2C_POINTER,
    output I2C_WDATA8,
    input  I2C_END_OK,
    input  I2C_ACK_OK
  );

  modport slave (
    input  I2C_GO,
    input  I2C_SLAVE_ADDRESS,
    input  I2C_POINTER,
    input  I2C_WDATA8,
    output I2C_END_OK,
    output I2C_ACK_OK
  );

endinterface

// File: rtl/i2c_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first valid requester at or
// after ptr_i, wrapping to index 0.
module rr_arbiter #(
  parameter  int NREQ  = 2,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] idx_o
);

  // First pass covers [ptr_i, NREQ-1]; the second pass only fires when nothing
  // there is valid, so it naturally picks the lowest index below ptr_i.
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would infer a latch.
    any_o   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!any_o && valid_i[j] && (IDX_W'(j) >= ptr_i)) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!any_o && valid_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_write_scheduler.sv
// Arbitrates NREQ requesters onto one I2C 3-byte write engine, sequences the
// GO/END_OK handshake, retries NACKed writes and aborts stalled phases.
module i2c_write_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int BOOT_DLY  = 64,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 2047,
  parameter int GAP       = 8
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic [NREQ-1:0]            REQ_VALID,
  input  logic [I2C_BYTE_W*NREQ-1:0] REQ_SLAVE,
  input  logic [I2C_BYTE_W*NREQ-1:0] REQ_PTR,
  input  logic [I2C_BYTE_W*NREQ-1:0] REQ_DATA,
  output logic [NREQ-1:0]            REQ_READY,
  output logic [NREQ-1:0]            DONE,
  output logic                       DONE_ERR,
  i2c_eng_if.master                  eng,
  output logic                       BUSY,
  output byte_t                      ERR_CNT
);

  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_MAX = (TIMEOUT > BOOT_DLY) ? ((TIMEOUT > GAP) ? TIMEOUT : GAP)
                                                : ((BOOT_DLY > GAP) ? BOOT_DLY : GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  ready_q, ready_d;
  wr_cmd_t          cmd_q, cmd_d;
  logic             go_q, go_d;
  logic             ack_q;
  byte_t            err_cnt_q, err_cnt_d;

  logic             arb_any;
  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  wr_cmd_t          arb_cmd;
  logic             phase_timeout;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid_i (REQ_VALID),
    .ptr_i   (rr_q),
    .any_o   (arb_any),
    .grant_o (arb_gnt),
    .idx_o   (arb_idx)
  );

  // One-hot grant makes the field mux a plain AND-OR.
  always_comb begin
    arb_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        arb_cmd.slave = arb_cmd.slave | REQ_SLAVE[i*I2C_BYTE_W +: I2C_BYTE_W];
        arb_cmd.ptr   = arb_cmd.ptr   | REQ_PTR[i*I2C_BYTE_W +: I2C_BYTE_W];
        arb_cmd.data  = arb_cmd.data  | REQ_DATA[i*I2C_BYTE_W +: I2C_BYTE_W];
      end
    end
  end

  assign phase_timeout = (cnt_q == CNT_W'(TIMEOUT));

  // The engine starts a write whenever it is idle and sees GO low, so GO is
  // only ever driven low for the launch phase.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    retry_d   = retry_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    cmd_d     = cmd_q;
    go_d      = 1'b1;
    ready_d   = '0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      S_BOOT: begin
        if (cnt_q == CNT_W'(BOOT_DLY - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (arb_any) begin
          gnt_d   = arb_gnt;
          cmd_d   = arb_cmd;
          ready_d = arb_gnt;
          retry_d = '0;
          rr_d    = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          go_d    = 1'b0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!eng.I2C_END_OK)  state_d = S_WAIT_END;
        else if (phase_timeout) state_d = S_FAIL;
        else                  go_d    = 1'b0;
      end
      S_WAIT_END: begin
        // ack_q holds the final-byte ACK sampled the cycle before END_OK rose.
        if (eng.I2C_END_OK)     state_d = ack_q ? S_DONE : S_RETRY;
        else if (phase_timeout) state_d = S_RETRY;
      end
      S_RETRY: begin
        if (retry_q == RTY_W'(MAX_RETRY)) begin
          state_d = S_FAIL;
        end else if (cnt_q == CNT_W'(GAP - 1)) begin
          retry_d = retry_q + 1'b1;
          go_d    = 1'b0;
          state_d = S_LAUNCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAIL: begin
        err_cnt_d = sat_inc(err_cnt_q);
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_BOOT;
      cnt_q     <= '0;
      retry_q   <= '0;
      rr_q      <= '0;
      gnt_q     <= '0;
      ready_q   <= '0;
      cmd_q     <= '0;
      go_q      <= 1'b1;
      ack_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      ready_q   <= ready_d;
      cmd_q     <= cmd_d;
      go_q      <= go_d;
      ack_q     <= eng.I2C_ACK_OK;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign REQ_READY             = ready_q;
  assign DONE                  = ((state_q == S_DONE) || (state_q == S_FAIL)) ? gnt_q : '0;
  assign DONE_ERR              = (state_q == S_FAIL);
  assign BUSY                  = (state_q != S_IDLE);
  assign ERR_CNT               = err_cnt_q;
  assign eng.I2C_GO            = go_q;
  assign eng.I2C_SLAVE_ADDRESS = cmd_q.slave;
  assign eng.I2C_POINTER       = cmd_q.ptr;
  assign eng.I2C_WDATA8        = cmd_q.data;

endmodule
